// File: rtl/ram_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ram_pkg                                                                   |
// | Shared constants and helpers for the word-wide RAM wrapper.               |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package ram_pkg;

  localparam int BYTE_W = 8;

  // A depth-1 FIFO still needs a one-bit pointer to index its storage.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_lane.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ram_lane                                                                  |
// | One byte lane: single-port synchronous RAM with registered read data.     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module ram_lane
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BYTE_W-1:0]     i_din,
  output logic [BYTE_W-1:0]     o_dout
);

  logic [BYTE_W-1:0] r_mem [2**ADDR_WIDTH];
  logic [BYTE_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_din;
    end
    r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/ram_wide_port.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | ram_wide_port                                                             |
// | Word-wide strobed RAM with valid/ready requests and credit-checked,       |
// | tagged read responses buffered in a small in-order FIFO.                  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module ram_wide_port
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_BYTES = 4,
  parameter int ID_WIDTH   = 4,
  parameter int RESP_DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         req_valid_in,
  output logic                         req_ready_out,
  input  logic                         req_we_in,
  input  logic [ADDR_WIDTH-1:0]        req_addr_in,
  input  logic [BYTE_W*DATA_BYTES-1:0] req_wdata_in,
  input  logic [DATA_BYTES-1:0]        req_strb_in,
  input  logic [ID_WIDTH-1:0]          req_id_in,
  output logic                         resp_valid_out,
  input  logic                         resp_ready_in,
  output logic [BYTE_W*DATA_BYTES-1:0] resp_rdata_out,
  output logic [ID_WIDTH-1:0]          resp_id_out
);

  localparam int DATA_W = BYTE_W * DATA_BYTES;
  localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;
  localparam int PTR_W  = ptr_width(RESP_DEPTH);

  logic              w_accept;
  logic              w_rd_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [CNT_W:0]    w_pending;
  logic [DATA_W-1:0] w_lane_dout;

  logic                r_inflight;
  logic [ID_WIDTH-1:0] r_inflight_id;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_fifo_data [RESP_DEPTH];
  logic [ID_WIDTH-1:0] r_fifo_id   [RESP_DEPTH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Credits cover the read still in the RAM pipeline, so a push can never overflow.
  assign w_pending     = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign req_ready_out = (w_pending < (CNT_W+1)'(RESP_DEPTH));
  assign w_accept      = req_valid_in & req_ready_out;
  assign w_rd_accept   = w_accept & ~req_we_in;
  assign w_push        = r_inflight;
  assign w_pop         = resp_valid_out & resp_ready_in;
  assign w_full        = (r_count == CNT_W'(RESP_DEPTH));

  generate
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
      ram_lane #(
        .ADDR_WIDTH (ADDR_WIDTH)
      ) u_lane (
        .clk    (clk_in),
        .i_we   (w_accept & req_we_in & req_strb_in[i]),
        .i_addr (req_addr_in),
        .i_din  (req_wdata_in[i*BYTE_W +: BYTE_W]),
        .o_dout (w_lane_dout[i*BYTE_W +: BYTE_W])
      );
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= w_rd_accept;
      if (w_rd_accept) begin
        r_inflight_id <= req_id_in;
      end
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_lane_dout;
      r_fifo_id[r_wr_ptr]   <= r_inflight_id;
    end
  end

  assign resp_valid_out = (r_count != '0);
  assign resp_rdata_out = resp_valid_out ? r_fifo_data[r_rd_ptr] : '0;
  assign resp_id_out    = resp_valid_out ? r_fifo_id[r_rd_ptr]   : '0;

`ifndef SYNTHESIS
  always @(posedge clk_in) begin
    if (rst_n_in) begin
      assert (!(w_push && w_full && !w_pop))
        else $error("ram_wide_port: response fifo push while full");
      assert (w_pending <= (CNT_W+1)'(RESP_DEPTH))
        else $error("ram_wide_port: pending credits exceed response depth");
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_wide_port.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_ram_wide_port                                                          |
// | Directed self-checking bench for ram_wide_port (RESP_DEPTH = 2).          |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_ram_wide_port;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic        req_we_in = 1'b0;
  logic [14:0] req_addr_in = '0;
  logic [31:0] req_wdata_in = '0;
  logic [3:0]  req_strb_in = '0;
  logic [3:0]  req_id_in = '0;
  logic        resp_valid_out;
  logic        resp_ready_in = 1'b1;
  logic [31:0] resp_rdata_out;
  logic [3:0]  resp_id_out;

  int checks = 0;
  int errors = 0;

  ram_wide_port #(
    .ADDR_WIDTH (15),
    .DATA_BYTES (4),
    .ID_WIDTH   (4),
    .RESP_DEPTH (2)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .req_valid_in   (req_valid_in),
    .req_ready_out  (req_ready_out),
    .req_we_in      (req_we_in),
    .req_addr_in    (req_addr_in),
    .req_wdata_in   (req_wdata_in),
    .req_strb_in    (req_strb_in),
    .req_id_in      (req_id_in),
    .resp_valid_out (resp_valid_out),
    .resp_ready_in  (resp_ready_in),
    .resp_rdata_out (resp_rdata_out),
    .resp_id_out    (resp_id_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid_in = 1'b1;
    req_we_in    = 1'b1;
    req_addr_in  = a;
    req_wdata_in = d;
    req_strb_in  = s;
    tick();
    req_valid_in = 1'b0;
    req_we_in    = 1'b0;
  endtask

  task automatic do_read(input logic [14:0] a, input logic [3:0] id);
    req_valid_in = 1'b1;
    req_we_in    = 1'b0;
    req_addr_in  = a;
    req_id_in    = id;
    tick();
    req_valid_in = 1'b0;
  endtask

  function automatic logic [31:0] word_at(input logic [14:0] a);
    case (a)
      15'd1:   return 32'h1111_0001;
      15'd2:   return 32'h2222_0002;
      default: return 32'h3333_0003;
    endcase
  endfunction

  initial begin
    logic [8:0]  pre_rdy;
    logic [8:0]  post_v;
    logic [3:0]  nid;
    logic [3:0]  hid;

    // Asynchronous reset asserted mid-cycle.
    @(posedge clk_in);
    #3 rst_n_in = 1'b0;
    #1;
    check("rst_valid", resp_valid_out, 0);
    check("rst_rdata", resp_rdata_out, 0);
    check("rst_id", resp_id_out, 0);
    tick();
    tick();
    rst_n_in = 1'b1;
    check("rst_ready", req_ready_out, 1);

    // Full-word write and read latency.
    do_write(15'h10, 32'hDEAD_BEEF, 4'hF);
    do_read(15'h10, 4'd3);
    check("lat_cycle1_valid", resp_valid_out, 0);
    tick();
    check("lat_cycle2_valid", resp_valid_out, 1);
    check("full_rdata", resp_rdata_out, 32'hDEAD_BEEF);
    check("full_id", resp_id_out, 3);
    tick();
    check("pop_empty_valid", resp_valid_out, 0);
    check("pop_empty_rdata", resp_rdata_out, 0);

    // Partial strobes, then a strobe-less write that must change nothing.
    do_write(15'h10, 32'h1122_3344, 4'b0101);
    do_read(15'h10, 4'd4);
    tick();
    check("strb_rdata", resp_rdata_out, 32'hDE22_BE44);
    check("strb_id", resp_id_out, 4);
    tick();
    do_write(15'h10, 32'hFFFF_FFFF, 4'b0000);
    do_read(15'h10, 4'd7);
    tick();
    check("strb0_rdata", resp_rdata_out, 32'hDE22_BE44);
    tick();

    // Backpressure: only two credits.
    do_write(15'd1, 32'h1111_0001, 4'hF);
    do_write(15'd2, 32'h2222_0002, 4'hF);
    do_write(15'd3, 32'h3333_0003, 4'hF);
    resp_ready_in = 1'b0;
    req_valid_in  = 1'b1;
    req_we_in     = 1'b0;
    req_addr_in   = 15'd1;
    req_id_in     = 4'd1;
    check("bp_ready0", req_ready_out, 1);
    tick();
    req_addr_in = 15'd2;
    req_id_in   = 4'd2;
    check("bp_ready1", req_ready_out, 1);
    tick();
    req_addr_in = 15'd3;
    req_id_in   = 4'd3;
    check("bp_ready2", req_ready_out, 0);
    tick();
    check("bp_ready3", req_ready_out, 0);
    check("bp_head_valid", resp_valid_out, 1);
    check("bp_head_id", resp_id_out, 1);
    tick();
    check("bp_hold_id", resp_id_out, 1);
    check("bp_hold_rdata", resp_rdata_out, 32'h1111_0001);
    check("bp_hold_ready", req_ready_out, 0);
    resp_ready_in = 1'b1;
    tick();
    check("bp_second_id", resp_id_out, 2);
    check("bp_second_rdata", resp_rdata_out, 32'h2222_0002);
    check("bp_credit_back", req_ready_out, 1);
    tick();
    req_valid_in = 1'b0;
    check("bp_third_inflight", resp_valid_out, 0);
    tick();
    check("bp_third_valid", resp_valid_out, 1);
    check("bp_third_id", resp_id_out, 3);
    check("bp_third_rdata", resp_rdata_out, 32'h3333_0003);
    tick();
    check("bp_drained", resp_valid_out, 0);

    // Continuous requests: ready is pending < 2, so accepts settle at 2 of every 3 cycles.
    pre_rdy = 9'b011011011;
    post_v  = 9'b110110110;
    nid = 4'd8;
    hid = 4'd8;
    req_valid_in = 1'b1;
    req_we_in    = 1'b0;
    for (int k = 0; k < 9; k++) begin
      req_addr_in = 15'd1 + 15'(nid % 3);
      req_id_in   = nid;
      check($sformatf("b2b_ready_%0d", k), req_ready_out, pre_rdy[k]);
      tick();
      if (pre_rdy[k]) nid = nid + 4'd1;
      check($sformatf("b2b_valid_%0d", k), resp_valid_out, post_v[k]);
      if (post_v[k]) begin
        check($sformatf("b2b_id_%0d", k), resp_id_out, hid);
        check($sformatf("b2b_rdata_%0d", k), resp_rdata_out, word_at(15'd1 + 15'(hid % 3)));
        hid = hid + 4'd1;
      end
    end
    req_valid_in = 1'b0;
    tick();
    check("b2b_drained", resp_valid_out, 0);
    check("b2b_count", hid, 4'd14);

    // Reset while a read is in flight discards it.
    do_read(15'h10, 4'd5);
    rst_n_in = 1'b0;
    #1;
    check("rst_mid_valid", resp_valid_out, 0);
    tick();
    tick();
    rst_n_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rst_mid_quiet_%0d", k), resp_valid_out, 0);
    end
    do_read(15'h10, 4'd6);
    tick();
    check("post_rst_valid", resp_valid_out, 1);
    check("post_rst_id", resp_id_out, 6);
    check("post_rst_rdata", resp_rdata_out, 32'hDE22_BE44);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
